// File: rtl/dmem_arbiter.sv
// Shares one dual-width dmem between the 16-bit scalar port and the 256-bit vector port.
// Burst-limited round-robin grant, dmem drive mux, and in-order read-return routing.
module dmem_arbiter #(
    parameter int RD_LAT    = 2,
    parameter int MAX_BURST = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_s_req,
    input  logic         i_s_we,
    input  logic [31:0]  i_s_addr,
    input  logic [15:0]  i_s_wdata,
    output logic         o_s_gnt,
    output logic         o_s_rvalid,
    output logic [15:0]  o_s_rdata,
    input  logic         i_v_req,
    input  logic         i_v_we,
    input  logic [31:0]  i_v_addr,
    input  logic [255:0] i_v_wdata,
    output logic         o_v_gnt,
    output logic         o_v_rvalid,
    output logic [255:0] o_v_rdata,
    output logic         o_mem_we,
    output logic         o_mem_src_sel,
    output logic [31:0]  o_mem_addr,
    output logic [15:0]  o_mem_wdata_a,
    output logic [255:0] o_mem_wdata_b,
    input  logic [15:0]  i_mem_q_a,
    input  logic [255:0] i_mem_q_b,
    output logic [1:0]   o_dbg_owner
);

    // Handshake: a port holds req with its command stable; gnt high in the same
    // cycle means the access was issued to dmem this cycle (transfer = req & gnt).

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);
    localparam logic SRC_S = 1'b0;
    localparam logic SRC_V = 1'b1;

    typedef enum logic [1:0] {
        OWN_IDLE   = 2'd0,
        OWN_SCALAR = 2'd1,
        OWN_VECTOR = 2'd2
    } owner_t;

    owner_t          r_owner;
    owner_t          w_owner_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            r_last;
    logic            w_last_nxt;
    logic [RD_LAT-1:0] r_pipe_vld;
    logic [RD_LAT-1:0] r_pipe_src;
    logic            w_gnt_s;
    logic            w_gnt_v;
    logic            w_rd_issue;

    // State register, including the in-flight read tracker.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_owner    <= OWN_IDLE;
            r_cnt      <= '0;
            r_last     <= SRC_V;
            r_pipe_vld <= '0;
            r_pipe_src <= '0;
        end else begin
            r_owner       <= w_owner_nxt;
            r_cnt         <= w_cnt_nxt;
            r_last        <= w_last_nxt;
            r_pipe_vld[0] <= w_rd_issue;
            r_pipe_src[0] <= w_gnt_v;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_src[i] <= r_pipe_src[i-1];
            end
        end
    end

    // Grant decision and next state.
    always_comb begin
        w_gnt_s = 1'b0;
        w_gnt_v = 1'b0;
        if (!i_rst) begin
            if (i_s_req && !i_v_req) begin
                w_gnt_s = 1'b1;
            end else if (!i_s_req && i_v_req) begin
                w_gnt_v = 1'b1;
            end else if (i_s_req && i_v_req) begin
                if (r_owner == OWN_IDLE) begin
                    w_gnt_s = (r_last == SRC_V);
                    w_gnt_v = (r_last == SRC_S);
                end else if (r_cnt < MAX_CNT) begin
                    w_gnt_s = (r_owner == OWN_SCALAR);
                    w_gnt_v = (r_owner == OWN_VECTOR);
                end else begin
                    w_gnt_s = (r_owner == OWN_VECTOR);
                    w_gnt_v = (r_owner == OWN_SCALAR);
                end
            end
        end

        w_owner_nxt = OWN_IDLE;
        w_cnt_nxt   = '0;
        w_last_nxt  = r_last;
        if (w_gnt_s || w_gnt_v) begin
            w_owner_nxt = w_gnt_v ? OWN_VECTOR : OWN_SCALAR;
            w_last_nxt  = w_gnt_v;
            // Counter saturates so a long solo stream cannot wrap back under the limit.
            if (w_owner_nxt == r_owner)
                w_cnt_nxt = (r_cnt < MAX_CNT) ? r_cnt + CW'(1) : r_cnt;
            else
                w_cnt_nxt = CW'(1);
        end

        w_rd_issue = (w_gnt_s && !i_s_we) || (w_gnt_v && !i_v_we);
    end

    // Outputs: dmem drive mux and read-return routing.
    always_comb begin
        o_s_gnt       = w_gnt_s;
        o_v_gnt       = w_gnt_v;
        o_mem_src_sel = w_gnt_v;
        o_mem_we      = 1'b0;
        o_mem_addr    = '0;
        o_mem_wdata_a = '0;
        o_mem_wdata_b = '0;
        if (w_gnt_s) begin
            o_mem_we      = i_s_we;
            o_mem_addr    = i_s_addr;
            o_mem_wdata_a = i_s_wdata;
        end else if (w_gnt_v) begin
            o_mem_we      = i_v_we;
            o_mem_addr    = i_v_addr;
            o_mem_wdata_b = i_v_wdata;
        end

        o_s_rvalid  = r_pipe_vld[RD_LAT-1] && (r_pipe_src[RD_LAT-1] == SRC_S);
        o_v_rvalid  = r_pipe_vld[RD_LAT-1] && (r_pipe_src[RD_LAT-1] == SRC_V);
        o_s_rdata   = o_s_rvalid ? i_mem_q_a : '0;
        o_v_rdata   = o_v_rvalid ? i_mem_q_b : '0;
        o_dbg_owner = r_owner;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed grant/drive checks plus a
// read-return scoreboard fed by a small latency-accurate dmem model.
module tb_dmem_arbiter;

  localparam int RD_LAT    = 2;
  localparam int MAX_BURST = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_req, s_we, s_gnt, s_rvalid;
  logic [31:0]  s_addr;
  logic [15:0]  s_wdata, s_rdata;
  logic         v_req, v_we, v_gnt, v_rvalid;
  logic [31:0]  v_addr;
  logic [255:0] v_wdata, v_rdata;
  logic         mem_we, mem_src_sel;
  logic [31:0]  mem_addr;
  logic [15:0]  mem_wdata_a, mem_q_a;
  logic [255:0] mem_wdata_b, mem_q_b;
  logic [1:0]   dbg_owner;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  logic [15:0]  s_exp_q[$];
  logic [255:0] v_exp_q[$];
  int           s_cyc_q[$];
  int           v_cyc_q[$];
  logic [31:0]  a_pipe[RD_LAT];

  dmem_arbiter #(.RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_s_req(s_req), .i_s_we(s_we), .i_s_addr(s_addr), .i_s_wdata(s_wdata),
    .o_s_gnt(s_gnt), .o_s_rvalid(s_rvalid), .o_s_rdata(s_rdata),
    .i_v_req(v_req), .i_v_we(v_we), .i_v_addr(v_addr), .i_v_wdata(v_wdata),
    .o_v_gnt(v_gnt), .o_v_rvalid(v_rvalid), .o_v_rdata(v_rdata),
    .o_mem_we(mem_we), .o_mem_src_sel(mem_src_sel), .o_mem_addr(mem_addr),
    .o_mem_wdata_a(mem_wdata_a), .o_mem_wdata_b(mem_wdata_b),
    .i_mem_q_a(mem_q_a), .i_mem_q_b(mem_q_b), .o_dbg_owner(dbg_owner)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout n_chk=%0d", n_chk);
    $fatal(1, "timeout");
  end

  // ---------------- dmem model: q is a pure function of the address RD_LAT cycles ago
  function automatic logic [15:0] f_a(input logic [31:0] a);
    return a[15:0] ^ a[31:16] ^ 16'h5A5A;
  endfunction

  function automatic logic [255:0] f_b(input logic [31:0] a);
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = a ^ (32'h1111_1111 * 32'(k + 1));
    return r;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    a_pipe[0] <= mem_addr;
    for (int i = 1; i < RD_LAT; i++) a_pipe[i] <= a_pipe[i-1];
  end

  assign mem_q_a = f_a(a_pipe[RD_LAT-1]);
  assign mem_q_b = f_b(a_pipe[RD_LAT-1]);

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // ---------------- scoreboard: push on read issue, pop on return ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (s_rvalid) begin
        if (s_exp_q.size() == 0) check_eq("s_rvalid_unexp", s_rvalid, 0);
        else begin
          check_eq("s_rdata", s_rdata, s_exp_q.pop_front());
          check_eq("s_lat", cyc - s_cyc_q.pop_front(), RD_LAT);
        end
      end else check_eq("s_rdata_zero", s_rdata, 0);
      if (v_rvalid) begin
        if (v_exp_q.size() == 0) check_eq("v_rvalid_unexp", v_rvalid, 0);
        else begin
          check_eq("v_rdata", v_rdata, v_exp_q.pop_front());
          check_eq("v_lat", cyc - v_cyc_q.pop_front(), RD_LAT);
        end
      end else check_eq("v_rdata_zero", v_rdata, 0);
      if (s_gnt && !s_we) begin s_exp_q.push_back(f_a(s_addr)); s_cyc_q.push_back(cyc); end
      if (v_gnt && !v_we) begin v_exp_q.push_back(f_b(v_addr)); v_cyc_q.push_back(cyc); end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    s_req = 1'b0;
    v_req = 1'b0;
    repeat (n) step();
  endtask

  // ---------------- stimulus ----------------
  int  pend_s, pend_v, wait_s, wait_v;
  logic exp_s;

  initial begin
    rst = 1'b1;
    s_req = 1'b1; s_we = 1'b1; s_addr = 32'h100; s_wdata = 16'h1234;
    v_req = 1'b1; v_we = 1'b1; v_addr = 32'h200; v_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_s_gnt", s_gnt, 0);
    check_eq("rst_v_gnt", v_gnt, 0);
    check_eq("rst_s_rvalid", s_rvalid, 0);
    check_eq("rst_v_rvalid", v_rvalid, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_owner", dbg_owner, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Contention with both ports writing: S x4, V x4, S x4
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      exp_s = ((i / MAX_BURST) % 2) == 0;
      check_eq("cont_s_gnt", s_gnt, exp_s);
      check_eq("cont_v_gnt", v_gnt, !exp_s);
      check_eq("cont_src", mem_src_sel, !exp_s);
      check_eq("cont_mem_we", mem_we, 1);
      step();
      s_addr = $urandom; v_addr = $urandom;
    end
    idle(2);

    // Scalar-only stream saturates cnt; vector must then win at once
    s_req = 1'b1; s_we = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check_eq("solo_s_gnt", s_gnt, 1);
      step();
    end
    v_req = 1'b1; v_we = 1'b1;
    @(negedge clk);
    check_eq("sat_v_gnt", v_gnt, 1);
    check_eq("sat_s_gnt", s_gnt, 0);
    step();
    idle(2);

    // Single scalar read
    s_req = 1'b1; s_we = 1'b0; s_addr = 32'h10;
    @(negedge clk);
    check_eq("rd_s_gnt", s_gnt, 1);
    check_eq("rd_src", mem_src_sel, 0);
    check_eq("rd_addr", mem_addr, 32'h10);
    check_eq("rd_mem_we", mem_we, 0);
    step();
    idle(RD_LAT + 2);

    // Vector write
    v_req = 1'b1; v_we = 1'b1; v_addr = 32'h3; v_wdata = {32{8'hA5}};
    @(negedge clk);
    check_eq("vw_gnt", v_gnt, 1);
    check_eq("vw_mem_we", mem_we, 1);
    check_eq("vw_src", mem_src_sel, 1);
    check_eq("vw_addr", mem_addr, 32'h3);
    check_eq("vw_wdata_b", mem_wdata_b, {32{8'hA5}});
    step();
    idle(RD_LAT + 3);

    // Interleaved reads S@1, V@2, S@3 on consecutive cycles
    s_req = 1'b1; s_we = 1'b0; s_addr = 32'h1;
    @(negedge clk); check_eq("il_s0_gnt", s_gnt, 1);
    step();
    s_req = 1'b0; v_req = 1'b1; v_we = 1'b0; v_addr = 32'h2;
    @(negedge clk); check_eq("il_v_gnt", v_gnt, 1);
    step();
    v_req = 1'b0; s_req = 1'b1; s_addr = 32'h3;
    @(negedge clk); check_eq("il_s1_gnt", s_gnt, 1);
    step();
    idle(RD_LAT + 3);
    check_eq("il_s_q_empty", s_exp_q.size(), 0);
    check_eq("il_v_q_empty", v_exp_q.size(), 0);

    // Reset pulse one cycle after a read issue drops the read
    s_req = 1'b1; s_we = 1'b0; s_addr = 32'h20;
    @(negedge clk); check_eq("rp_s_gnt", s_gnt, 1);
    step();
    s_req = 1'b0;
    rst = 1'b1;
    s_exp_q.delete(); s_cyc_q.delete(); v_exp_q.delete(); v_cyc_q.delete();
    step();
    rst = 1'b0;
    check_eq("rp_owner", dbg_owner, 0);
    for (int i = 0; i < RD_LAT + 3; i++) begin
      @(negedge clk);
      check_eq("rp_s_rvalid", s_rvalid, 0);
      check_eq("rp_v_rvalid", v_rvalid, 0);
      step();
    end

    // Random traffic: one-hot grants, work conservation, bounded wait, read returns
    pend_s = 0; pend_v = 0; wait_s = 0; wait_v = 0;
    for (int n = 0; n < 300; n++) begin
      if (pend_s == 0 && $urandom_range(0, 2) != 0) begin
        pend_s = 1; s_we = 1'($urandom_range(0, 1)); s_addr = $urandom; s_wdata = 16'($urandom);
      end
      if (pend_v == 0 && $urandom_range(0, 2) != 0) begin
        pend_v = 1; v_we = 1'($urandom_range(0, 1)); v_addr = $urandom;
        for (int k = 0; k < 8; k++) v_wdata[k*32 +: 32] = $urandom;
      end
      s_req = (pend_s != 0);
      v_req = (pend_v != 0);
      @(negedge clk);
      check_eq("rnd_onehot", s_gnt & v_gnt, 0);
      if (s_gnt) begin
        check_eq("rnd_s_mem_we", mem_we, s_we);
        check_eq("rnd_s_addr", mem_addr, s_addr);
        pend_s = 0; wait_s = 0;
      end else if (pend_s != 0) begin
        check_eq("rnd_s_work", v_gnt, 1);
        wait_s++;
        check_eq("rnd_s_wait", wait_s <= MAX_BURST, 1);
      end
      if (v_gnt) begin
        check_eq("rnd_v_mem_we", mem_we, v_we);
        check_eq("rnd_v_addr", mem_addr, v_addr);
        pend_v = 0; wait_v = 0;
      end else if (pend_v != 0) begin
        check_eq("rnd_v_work", s_gnt, 1);
        wait_v++;
        check_eq("rnd_v_wait", wait_v <= MAX_BURST, 1);
      end
      step();
    end
    idle(RD_LAT + 3);
    check_eq("end_s_q_empty", s_exp_q.size(), 0);
    check_eq("end_v_q_empty", v_exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
